// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
// Shared constants for the modulo-N counter family.
//   UP / DOWN        : values of the 'up' direction input
//   WRAP / SATURATE  : values of the counter's WRAP parameter
//   modulus_ok()     : elaboration helper, true when 2 <= modulus <= 2^width
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  localparam int WRAP     = 1;
  localparam int SATURATE = 0;

  // Evaluated at elaboration; done in 64 bits so width=31/32 cannot overflow.
  function automatic bit modulus_ok(input int width, input int modulus);
    longint limit;
    limit = longint'(1) << width;
    return (longint'(modulus) >= 2) && (longint'(modulus) <= limit);
  endfunction

endpackage

// File: rtl/counter_modn_next.sv
// ---------------------------------------------------------------------------
// counter_modn_next
// Purely combinational next-value and range-check logic for counter_modn.
// Ports:
//   cnt       in   current count (LSB at bit 0)
//   cnt_in    in   parallel load value (LSB at bit 0)
//   en        in   count enable
//   up        in   direction (UP / DOWN)
//   loadn     in   active-low load request
//   cnt_next  out  value the register takes on the next edge
//   load_bad  out  cnt_in is outside 0..MODULUS-1
//   at_bound  out  count sits on the bound for the current direction
// ---------------------------------------------------------------------------
module counter_modn_next #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter int WRAP    = 1
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             en,
  input  logic             up,
  input  logic             loadn,
  output logic [WIDTH-1:0] cnt_next,
  output logic             load_bad,
  output logic             at_bound
);
  import counter_pkg::*;

  // Compare against MODULUS-1, which always fits in WIDTH bits, so the
  // MODULUS == 2^WIDTH case never needs an extra carry bit.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic             WRAP_EN = (WRAP == counter_pkg::WRAP);

  logic at_max;
  logic at_min;

  always_comb begin
    at_max   = (cnt == MAX_VAL);
    at_min   = (cnt == '0);
    load_bad = (cnt_in > MAX_VAL);
    at_bound = (up == UP) ? at_max : at_min;

    cnt_next = cnt;
    if (!loadn) begin
      // Out-of-range loads land on zero; the flag is raised by the top.
      cnt_next = load_bad ? '0 : cnt_in;
    end else if (en) begin
      if (up == UP) begin
        cnt_next = at_max ? (WRAP_EN ? '0 : cnt) : cnt + 1'b1;
      end else if (up == DOWN) begin
        cnt_next = at_min ? (WRAP_EN ? MAX_VAL : cnt) : cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_modn.sv
// ---------------------------------------------------------------------------
// counter_modn
// Up/down modulo-MODULUS counter with parallel load, wrap or saturate at the
// bounds, terminal-count output for cascading, and a sticky load-error flag.
// Ports:
//   clk     in   rising-edge clock
//   clrn    in   asynchronous active-low clear
//   en      in   count enable
//   up      in   1 = count up, 0 = count down
//   loadn   in   synchronous active-low load (beats en)
//   CNT_in  in   load value, bit 0 is the MSB
//   CNT     out  current count, bit 0 is the MSB
//   tc      out  terminal count, drive the next stage's en with it
//   zero    out  CNT == 0
//   err     out  sticky: last load was out of range
// ---------------------------------------------------------------------------
module counter_modn #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 6,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             en,
  input  logic             up,
  input  logic             loadn,
  input  logic [0:WIDTH-1] CNT_in,
  output logic [0:WIDTH-1] CNT,
  output logic             tc,
  output logic             zero,
  output logic             err
);
  import counter_pkg::*;

  // Refuse to build a counter whose range cannot be held in WIDTH bits.
  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("counter_modn: MODULUS=%0d outside 2..2^%0d", MODULUS, WIDTH);
  end
  if (WRAP != counter_pkg::WRAP && WRAP != SATURATE) begin : g_bad_wrap
    $error("counter_modn: WRAP=%0d must be 0 or 1", WRAP);
  end

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] cnt_in_lsb0;
  logic             err_q;
  logic             err_d;
  logic             load_bad;
  logic             at_bound;

  // Positional assignment keeps the MSB on the left, so external bit 0
  // (the MSB) becomes internal bit WIDTH-1.
  assign cnt_in_lsb0 = CNT_in;

  counter_modn_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .WRAP    (WRAP)
  ) u_next (
    .cnt      (cnt_q),
    .cnt_in   (cnt_in_lsb0),
    .en       (en),
    .up       (up),
    .loadn    (loadn),
    .cnt_next (cnt_next),
    .load_bad (load_bad),
    .at_bound (at_bound)
  );

  // err only changes on a load; counting never touches it.
  always_comb begin
    cnt_d = cnt_next;
    err_d = loadn ? err_q : load_bad;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // tc is suppressed during a load so a cascaded stage does not step while
  // this stage is being overwritten.
  assign tc   = en & loadn & at_bound;
  assign zero = (cnt_q == '0);
  assign err  = err_q;
  assign CNT  = cnt_q;

endmodule

// File: tb/tb_counter_modn.sv
// ---------------------------------------------------------------------------
// tb_counter_modn
// Drives three single counters (6/wrap, 10/saturate, 16/wrap) with shared
// inputs plus a two-stage decade cascade, and compares every output with an
// arithmetic model on every falling clock edge.
// ---------------------------------------------------------------------------
module tb_counter_modn;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       loadn = 1'b1;
  logic       casc_en = 1'b0;
  logic [0:3] cnt_in = '0;

  logic [0:3] cnt_a, cnt_b, cnt_c, cnt_s0, cnt_s1;
  logic       tc_a, tc_b, tc_c, tc_s0, tc_s1;
  logic       zero_a, zero_b, zero_c, zero_s0, zero_s1;
  logic       err_a, err_b, err_c, err_s0, err_s1;

  int checks = 0;
  int passed = 0;
  bit cmp_on = 1'b0;

  int mcnt [3];
  bit merr [3];
  int casc_n = 0;
  int mod_of [3] = '{6, 10, 16};
  bit wrap_of [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  counter_modn #(.WIDTH(4), .MODULUS(6), .WRAP(1)) dut_a (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .loadn(loadn), .CNT_in(cnt_in),
    .CNT(cnt_a), .tc(tc_a), .zero(zero_a), .err(err_a));

  counter_modn #(.WIDTH(4), .MODULUS(10), .WRAP(0)) dut_b (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .loadn(loadn), .CNT_in(cnt_in),
    .CNT(cnt_b), .tc(tc_b), .zero(zero_b), .err(err_b));

  counter_modn #(.WIDTH(4), .MODULUS(16), .WRAP(1)) dut_c (
    .clk(clk), .clrn(clrn), .en(en), .up(up), .loadn(loadn), .CNT_in(cnt_in),
    .CNT(cnt_c), .tc(tc_c), .zero(zero_c), .err(err_c));

  counter_modn #(.WIDTH(4), .MODULUS(10), .WRAP(1)) dut_s0 (
    .clk(clk), .clrn(clrn), .en(casc_en), .up(1'b1), .loadn(1'b1), .CNT_in(4'd0),
    .CNT(cnt_s0), .tc(tc_s0), .zero(zero_s0), .err(err_s0));

  counter_modn #(.WIDTH(4), .MODULUS(10), .WRAP(1)) dut_s1 (
    .clk(clk), .clrn(clrn), .en(tc_s0), .up(1'b1), .loadn(1'b1), .CNT_in(4'd0),
    .CNT(cnt_s1), .tc(tc_s1), .zero(zero_s1), .err(err_s1));

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input logic ld, input logic e, input logic u,
                               input logic [3:0] cin);
    loadn  = ld;
    en     = e;
    up     = u;
    cnt_in = cin;
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: range 0..m-1, load beats count, wrap or stick.
  function automatic int model_next(input int c, input bit ld, input bit e,
                                    input bit u, input int cin, input int m,
                                    input bit wrap);
    if (!ld) return (cin < m) ? cin : 0;
    if (!e) return c;
    if (u) return (c == m - 1) ? (wrap ? 0 : c) : c + 1;
    return (c == 0) ? (wrap ? m - 1 : 0) : c - 1;
  endfunction

  // Model state; the cascade is just a count of enabled edges.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i] <= 0;
        merr[i] <= 1'b0;
      end
      casc_n <= 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i] <= model_next(mcnt[i], loadn, en, up, int'(cnt_in), mod_of[i], wrap_of[i]);
        merr[i] <= !loadn ? (int'(cnt_in) >= mod_of[i]) : merr[i];
      end
      if (casc_en) casc_n <= casc_n + 1;
    end
  end

  // Compare process: all outputs against the model on each falling edge.
  always @(negedge clk) begin
    int ac [3];
    int at [3];
    int az [3];
    int ae [3];
    int exp_tc;
    if (cmp_on) begin
      ac = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
      at = '{int'(tc_a), int'(tc_b), int'(tc_c)};
      az = '{int'(zero_a), int'(zero_b), int'(zero_c)};
      ae = '{int'(err_a), int'(err_b), int'(err_c)};
      for (int i = 0; i < 3; i++) begin
        exp_tc = int'(en && loadn && ((up && mcnt[i] == mod_of[i] - 1) ||
                                      (!up && mcnt[i] == 0)));
        checkOutput($sformatf("cnt[%0d]", i), ac[i], mcnt[i]);
        checkOutput($sformatf("tc[%0d]", i), at[i], exp_tc);
        checkOutput($sformatf("zero[%0d]", i), az[i], int'(mcnt[i] == 0));
        checkOutput($sformatf("err[%0d]", i), ae[i], int'(merr[i]));
      end
      checkOutput("casc_s0", int'(cnt_s0), casc_n % 10);
      checkOutput("casc_s1", int'(cnt_s1), (casc_n / 10) % 10);
      checkOutput("casc_tc0", int'(tc_s0), int'(casc_en && (casc_n % 10 == 9)));
      checkOutput("casc_zero", int'({zero_s0, zero_s1}),
                  int'({casc_n % 10 == 0, (casc_n / 10) % 10 == 0}));
      checkOutput("casc_err", int'({err_s0, err_s1, tc_s1}),
                  int'({2'b00, casc_en && (casc_n % 100 == 99)}));
    end
  end

  initial begin
    cmp_on = 1'b1;

    // Reset takes effect with no clock edge.
    #1;
    clrn = 1'b0;
    en   = 1'b1;
    up   = 1'b1;
    #1;
    checkOutput("rst_cnt", int'(cnt_a), 0);
    checkOutput("rst_zero", int'(zero_a), 1);
    checkOutput("rst_err", int'(err_a), 0);
    checkOutput("rst_tc", int'(tc_a), 0);
    @(posedge clk);
    #1;
    clrn = 1'b1;

    // Up-count through the wrap point.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0011);
    checkOutput("load3", int'(cnt_a), 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("up_4", int'(cnt_a), 4);
    checkOutput("model_pin4", mcnt[0], 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("up_5", int'(cnt_a), 5);
    checkOutput("up_tc5", int'(tc_a), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("up_wrap0", int'(cnt_a), 0);
    checkOutput("up_zero", int'(zero_a), 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("up_1", int'(cnt_a), 1);

    // Down-count through the borrow point.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("dn_0", int'(cnt_a), 0);
    checkOutput("dn_tc0", int'(tc_a), 1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("dn_5", int'(cnt_a), 5);
    checkOutput("model_pin5", mcnt[0], 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("dn_4", int'(cnt_a), 4);

    // Out-of-range load sets a sticky error.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0111);
    checkOutput("oor_cnt", int'(cnt_a), 0);
    checkOutput("oor_err", int'(err_a), 1);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    checkOutput("oor_sticky", int'(err_a), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
    checkOutput("oor_reload", int'(cnt_a), 2);
    checkOutput("oor_clear", int'(err_a), 0);

    // Load beats enable, and tc is masked during the load.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5);
    loadn  = 1'b0;
    en     = 1'b1;
    up     = 1'b1;
    cnt_in = 4'd4;
    #1;
    checkOutput("prio_tc", int'(tc_a), 0);
    @(posedge clk);
    #1;
    checkOutput("prio_cnt", int'(cnt_a), 4);

    // Asynchronous clear in the middle of a count.
    applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
    #2;
    clrn = 1'b0;
    #1;
    checkOutput("mid_rst_cnt", int'(cnt_a), 0);
    checkOutput("mid_rst_zero", int'(zero_a), 1);
    @(posedge clk);
    #1;
    checkOutput("rst_held", int'(cnt_a), 0);
    clrn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_after_rst", int'(cnt_a), 1);

    // Saturating decade counter holds at 9.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd8);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 4'd0);
      checkOutput("sat_9", int'(cnt_b), 9);
      checkOutput("sat_tc", int'(tc_b), 1);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd0);
    checkOutput("sat_dn8", int'(cnt_b), 8);

    // Full-range modulus wraps 15 -> 0 without overflow.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd15);
    checkOutput("m16_load", int'(cnt_c), 15);
    checkOutput("m16_err", int'(err_c), 0);
    loadn = 1'b1;
    en    = 1'b1;
    up    = 1'b1;
    #1;
    checkOutput("m16_tc", int'(tc_c), 1);
    @(posedge clk);
    #1;
    checkOutput("m16_wrap", int'(cnt_c), 0);

    // Two-stage cascade from reset.
    clrn = 1'b0;
    en   = 1'b0;
    #1;
    checkOutput("casc_rst", int'(cnt_s0), 0);
    @(posedge clk);
    #1;
    clrn    = 1'b1;
    casc_en = 1'b1;
    repeat (23) @(posedge clk);
    #1;
    casc_en = 1'b0;
    checkOutput("casc_23_s0", int'(cnt_s0), 3);
    checkOutput("casc_23_s1", int'(cnt_s1), 2);

    // Random traffic, occasional asynchronous clear pulses.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        clrn = 1'b0;
        #2;
        clrn = 1'b1;
      end
      loadn   = ($urandom_range(0, 7) != 0);
      en      = ($urandom_range(0, 3) != 0);
      up      = 1'($urandom_range(0, 1));
      cnt_in  = 4'($urandom_range(0, 15));
      casc_en = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
